// File: rtl/arbiter_n2_pkg.sv
// Shared types for the 2-requester arbiter and the shared output port that consumes its grant.
package arbiter_n2_pkg;

   localparam int N_REQ = 2;

   typedef logic [N_REQ-1:0] req_t;
   typedef logic [N_REQ-1:0] gnt_t;
   typedef logic             src_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } shport_state_t;

endpackage

// File: rtl/shared_port_n2_if.sv
// Bus bundle between the requesters/arbiter (master) and the shared port (slave).
interface shared_port_n2_if
   import arbiter_n2_pkg::*;
#(
   parameter int DW = 8
);
   gnt_t              gnt;
   logic [N_REQ-1:0]  in_valid;
   logic [DW-1:0]     in_data [0:N_REQ-1];
   logic [N_REQ-1:0]  in_last;
   logic [N_REQ-1:0]  in_ready;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic              out_last;
   src_t              out_src;
   logic              out_ready;
   logic [N_REQ-1:0]  done;
   logic              trunc;

   modport master (
      output gnt, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_src, done, trunc
   );

   modport slave (
      input  gnt, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_src, done, trunc
   );
endinterface

// File: rtl/shport_out_reg.sv
// Single registered output stage with valid/ready hold, reusable by any shared port.
module shport_out_reg #(
   parameter int W  = 8,
   parameter int SW = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [W-1:0]  ld_data,
   input  logic          ld_last,
   input  logic [SW-1:0] ld_src,
   input  logic          q_ready,
   output logic          q_valid,
   output logic [W-1:0]  q_data,
   output logic          q_last,
   output logic [SW-1:0] q_src,
   output logic          can_load
);

   // A beat moves when valid && ready; once q_valid rises the payload is frozen until it moves.
   // The caller only asserts load while can_load is high.
   assign can_load = !q_valid || q_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_valid <= 1'b0;
         q_data  <= '0;
         q_last  <= 1'b0;
         q_src   <= '0;
      end else if (load) begin
         q_valid <= 1'b1;
         q_data  <= ld_data;
         q_last  <= ld_last;
         q_src   <= ld_src;
      end else if (q_ready) begin
         q_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/shared_port_n2.sv
// Locks the shared output port to the granted requester for a whole burst.
// Optional burst length limit: define SHARED_PORT_BURST_LIMIT_EN.
module shared_port_n2
   import arbiter_n2_pkg::*;
#(
   parameter int DW        = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic          clk,
   input  logic          rst,
   shared_port_n2_if.slave bus,
   output shport_state_t dbg_state
);

   localparam logic [1:0] ST_IDLE  = 2'(IDLE);
   localparam logic [1:0] ST_BUSY  = 2'(BUSY);
   localparam logic [1:0] ST_DRAIN = 2'(DRAIN);

   if (MAX_BEATS < 2) begin : g_param_check
      $error("MAX_BEATS must be >= 2");
   end

   logic [1:0] state;
   src_t       sel;
   logic       can_load;
   logic       in_xfer;
   logic       out_xfer;
   logic       cut;
   logic       beat_last;

   assign in_xfer   = !rst && (state == ST_BUSY) && can_load && bus.in_valid[sel];
   assign out_xfer  = bus.out_valid && bus.out_ready;
   assign beat_last = bus.in_last[sel] || cut;
   assign dbg_state = shport_state_t'(state);

   always_comb begin
      bus.in_ready = '0;
      if (!rst && state == ST_BUSY) bus.in_ready[sel] = can_load;
   end

`ifdef SHARED_PORT_BURST_LIMIT_EN
   localparam int CW = $clog2(MAX_BEATS + 1);
   logic [CW-1:0] cnt;

   // Counter sits at zero in IDLE, so every burst starts counting from its first beat.
   always_ff @(posedge clk) begin
      if (rst || state == ST_IDLE) cnt <= '0;
      else if (in_xfer)            cnt <= cnt + CW'(1);
   end

   assign cut = in_xfer && !bus.in_last[sel] && (cnt == CW'(MAX_BEATS - 1));
`else
   assign cut = 1'b0;
`endif

   assign bus.trunc = cut;
   assign bus.done  = (!rst && state == ST_DRAIN && out_xfer) ?
                      (sel ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         sel   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // Only a clean one-hot grant opens a burst.
               if (bus.gnt == 2'b01) begin
                  sel   <= 1'b0;
                  state <= ST_BUSY;
               end else if (bus.gnt == 2'b10) begin
                  sel   <= 1'b1;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY:  if (in_xfer && beat_last) state <= ST_DRAIN;
            ST_DRAIN: if (out_xfer) state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   shport_out_reg #(.W(DW), .SW(1)) u_out (
      .clk      (clk),
      .rst      (rst),
      .load     (in_xfer),
      .ld_data  (bus.in_data[sel]),
      .ld_last  (beat_last),
      .ld_src   (sel),
      .q_ready  (bus.out_ready),
      .q_valid  (bus.out_valid),
      .q_data   (bus.out_data),
      .q_last   (bus.out_last),
      .q_src    (bus.out_src),
      .can_load (can_load)
   );

endmodule
